// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage types and constants.
//   fetch_state_t : fetch FSM state encoding
//   NOP_INSTR     : word delivered in place of a misaligned fetch
//   RESET_VECTOR  : fetch address out of reset
package cpu_pkg;
    typedef enum logic [1:0] {ISSUE, WAIT, DISCARD, HOLD} fetch_state_t;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register, priority flush > stall > load > bubble.
//   clk, reset      : clock, asynchronous active-high reset
//   flush_i         : invalidate the entry
//   stall_i         : hold every field
//   load_i          : capture instr_i/pc_i/err_i as a valid entry
//   instr_i, pc_i   : delivered word and its address
//   err_i           : delivered word is a misaligned-fetch NOP
//   valid_o, instr_o, pc_o, pc4_o, err_o : registered IF/ID contents
module if_id_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_i,
    input  logic        stall_i,
    input  logic        load_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic        err_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic        err_o
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_o <= 1'b0;
            instr_o <= '0;
            pc_o    <= '0;
            pc4_o   <= '0;
            err_o   <= 1'b0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
        end else if (!stall_i) begin
            // a bubble clears only valid; payload fields keep their value
            valid_o <= load_i;
            if (load_i) begin
                instr_o <= instr_i;
                pc_o    <= pc_i;
                pc4_o   <= pc_i + 32'd4;
                err_o   <= err_i;
            end
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: single-outstanding instruction fetch with skid buffer and PC hold.
//   clk, reset            : clock, asynchronous active-high reset
//   ia                    : current fetch address from the PC
//   stall                 : decode stall, IF/ID holds
//   flush                 : redirect, PC loads a new address this edge
//   pc_hold               : 1 keeps the PC on ia
//   imem_req, imem_addr   : memory request, issued on the edge it is high
//   imem_rvalid, imem_rdata : memory response
//   id_valid, id_instr, id_pc, id_pc4, id_fetch_err : IF/ID register
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ia,
    input  logic        stall,
    input  logic        flush,
    output logic        pc_hold,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        id_fetch_err
);
    fetch_state_t state_q, state_d;
    logic [31:0]  skid_q, skid_d, instr;
    logic         skid_err_q, skid_err_d, err, deliver, misaligned, is_issue, is_hold;

    assign misaligned = |ia[1:0];
    assign is_issue   = state_q == ISSUE;
    assign is_hold    = state_q == HOLD;
    assign deliver    = (state_q == WAIT && imem_rvalid) || is_hold || (is_issue && misaligned);
    assign instr      = is_hold ? skid_q : is_issue ? NOP_INSTR : imem_rdata;
    assign err        = is_hold ? skid_err_q : is_issue;
    assign imem_req   = is_issue && !flush && !misaligned && !reset;
    assign imem_addr  = ia;
    assign pc_hold    = reset || (!flush && !(deliver && !stall));
    // the PC is held while a word waits, so ia is still the address of the skid entry
    assign skid_d     = (deliver && stall && !flush && !is_hold) ? instr : skid_q;
    assign skid_err_d = (deliver && stall && !flush && !is_hold) ? err : skid_err_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ISSUE:   state_d = flush ? ISSUE : misaligned ? (stall ? HOLD : ISSUE) : WAIT;
            WAIT:    state_d = imem_rvalid ? ((stall && !flush) ? HOLD : ISSUE) : (flush ? DISCARD : WAIT);
            DISCARD: state_d = imem_rvalid ? ISSUE : DISCARD;
            HOLD:    state_d = (flush || !stall) ? ISSUE : HOLD;
            default: state_d = ISSUE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ISSUE;
            skid_q     <= '0;
            skid_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            skid_q     <= skid_d;
            skid_err_q <= skid_err_d;
        end
    end

    if_id_reg u_if_id (
        .clk     (clk),
        .reset   (reset),
        .flush_i (flush),
        .stall_i (stall),
        .load_i  (deliver),
        .instr_i (instr),
        .pc_i    (ia),
        .err_i   (err),
        .valid_o (id_valid),
        .instr_o (id_instr),
        .pc_o    (id_pc),
        .pc4_o   (id_pc4),
        .err_o   (id_fetch_err)
    );

    a_reset_pc: assert property (@(posedge clk) reset |-> ia == RESET_PC);
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with a PC model and variable-latency memory.
module tb_fetch_stage;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        err;
    } exp_t;

    logic        clk = 0, reset = 1, stall = 0, flush = 0, took = 0;
    logic [31:0] ia = 32'h8000_0000, tgt = 0, rdata_q = 0;
    logic        pc_hold, imem_req, imem_rvalid, id_valid, id_fetch_err;
    logic [31:0] imem_addr, imem_rdata, id_instr, id_pc, id_pc4;
    int          lat = 1, cnt = 0, tests = 0, fails = 0;
    exp_t        sb[$];

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .ia           (ia),
        .stall        (stall),
        .flush        (flush),
        .pc_hold      (pc_hold),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .id_valid     (id_valid),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .id_pc4       (id_pc4),
        .id_fetch_err (id_fetch_err)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hA008_0005;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk or posedge reset)
        if (reset) ia <= 32'h8000_0000;
        else if (flush) ia <= tgt;
        else if (!pc_hold) ia <= ia + 32'd4;

    // memory: responds lat cycles after the issuing edge; each accepted request becomes an expected IF/ID entry
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 0;
            sb.delete();
        end else begin
            if (flush) sb.delete();
            if (imem_req) begin
                cnt     <= lat;
                rdata_q <= word(imem_addr);
                sb.push_back('{imem_addr, word(imem_addr), imem_addr + 32'd4, 1'b0});
            end else if (cnt != 0) cnt <= cnt - 1;
        end
    end
    assign imem_rvalid = cnt == 1;
    assign imem_rdata  = rdata_q;

    // an edge with pc released and no flush must load IF/ID with the oldest expected entry
    always @(negedge clk) begin : mon
        exp_t e;
        if (took) begin
            chk("sb_have", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_valid", id_valid, 1);
                chk("sb_pc", id_pc, e.pc);
                chk("sb_instr", id_instr, e.instr);
                chk("sb_pc4", id_pc4, e.pc4);
                chk("sb_err", id_fetch_err, e.err);
            end
        end
        took = !pc_hold && !flush && !reset;
    end

    initial begin
        repeat (2) tick;
        chk("rst_valid", id_valid, 0);
        chk("rst_instr", id_instr, 0);
        chk("rst_pc", id_pc, 0);
        chk("rst_pc4", id_pc4, 0);
        chk("rst_err", id_fetch_err, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_hold", pc_hold, 1);
        reset = 0;
        #1;
        chk("c0_req", imem_req, 1);
        chk("c0_addr", imem_addr, 32'h8000_0000);
        chk("c0_hold", pc_hold, 1);
        tick;
        chk("c1_rvalid", imem_rvalid, 1);
        chk("c1_hold", pc_hold, 0);
        tick;
        chk("c2_valid", id_valid, 1);
        chk("c2_instr", id_instr, 32'h2008_0005);
        chk("c2_pc", id_pc, 32'h8000_0000);
        chk("c2_pc4", id_pc4, 32'h8000_0004);
        chk("c2_hold", pc_hold, 1);
        chk("c2_req", imem_req, 1);
        stall = 1;
        tick;
        chk("st_hold", pc_hold, 1);
        chk("st_keep_pc", id_pc, 32'h8000_0000);
        tick;
        chk("hd_hold", pc_hold, 1);
        chk("hd_req", imem_req, 0);
        chk("hd_keep_instr", id_instr, 32'h2008_0005);
        stall = 0;
        #1;
        chk("hd_release", pc_hold, 0);
        tick;
        chk("hd_loaded_pc", id_pc, 32'h8000_0004);
        chk("hd_loaded_instr", id_instr, 32'h2008_0001);
        lat = 3;
        tick;
        flush = 1;
        tgt = 32'h8000_0004;
        #1;
        chk("fl_hold", pc_hold, 0);
        tick;
        flush = 0;
        #1;
        chk("dc_valid", id_valid, 0);
        chk("dc_req", imem_req, 0);
        chk("dc_hold", pc_hold, 1);
        lat = 1;
        tick;
        chk("dc_req2", imem_req, 0);
        tick;
        chk("fl_next_req", imem_req, 1);
        chk("fl_next_addr", imem_addr, 32'h8000_0004);
        chk("fl_no_word", id_valid, 0);
        repeat (2) tick;
        flush = 1;
        tgt = 32'h8000_0002;
        tick;
        flush = 0;
        sb.push_back('{32'h8000_0002, 32'h0, 32'h8000_0006, 1'b1});
        #1;
        chk("mis_req", imem_req, 0);
        chk("mis_hold", pc_hold, 0);
        tick;
        chk("mis_valid", id_valid, 1);
        chk("mis_err", id_fetch_err, 1);
        chk("mis_instr", id_instr, 0);
        flush = 1;
        tgt = 32'hFFFF_FFFC;
        tick;
        flush = 0;
        #1;
        chk("wr_req", imem_req, 1);
        chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
        repeat (2) tick;
        chk("wr_pc", id_pc, 32'hFFFF_FFFC);
        chk("wr_pc4", id_pc4, 32'h0000_0000);
        chk("wr_err", id_fetch_err, 0);
        lat = 3;
        tick;
        reset = 1;
        #1;
        chk("mr_valid", id_valid, 0);
        chk("mr_instr", id_instr, 0);
        chk("mr_pc", id_pc, 0);
        chk("mr_pc4", id_pc4, 0);
        chk("mr_req", imem_req, 0);
        chk("mr_hold", pc_hold, 1);
        repeat (2) tick;
        reset = 0;
        lat = 1;
        #1;
        chk("mr_after_req", imem_req, 1);
        chk("mr_after_addr", imem_addr, 32'h8000_0000);
        repeat (6) tick;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage placed directly downstream of the program counter register. It takes the current fetch address `ia` and issues a single-outstanding request to instruction memory with variable response latency. It delivers the returned word into the IF/ID pipeline register and drives `pc_hold` back to the PC so that the PC advances only when an instruction has been handed to decode. Flush handling covers branch, irq and exception redirects and discards in-flight responses.

## Interface
- `RESET_PC`, default 32'h8000_0000: fetch address present during and immediately after reset; informational only, used in assertions.
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high. Clock is `clk`.
- `ia` in 32: current fetch address from the PC.
- `stall` in 1: decode/hazard stall; IF/ID must hold its contents.
- `flush` in 1: redirect (taken branch, irq, exception). The PC loads a new address this edge.
- `pc_hold` out 1: drives the PC's stall input. 1 means the PC must keep `ia`.
- `imem_req` out 1: request valid. The request is issued on the edge where it is sampled high.
- `imem_addr` out 32: request address, equal to `ia`.
- `imem_rvalid` in 1: response valid. Arrives at least 1 cycle after issue.
- `imem_rdata` in 32: response instruction word.
- `id_valid` out 1: the IF/ID register holds a real instruction.
- `id_instr` out 32: instruction word.
- `id_pc` out 32: address of `id_instr`.
- `id_pc4` out 32: `id_pc + 4`, modulo 2^32.
- `id_fetch_err` out 1: misaligned fetch; `id_instr` is NOP.

## Operation
- FSM states: ISSUE, WAIT, DISCARD, HOLD.
- **ISSUE**
  - `imem_req = ~flush & ~misaligned & ~reset`, where `misaligned = ia[1:0] != 0`.
  - If `flush`: stay in ISSUE.
  - If `misaligned`: deliver a NOP with `id_fetch_err=1`. No memory request. Stay in ISSUE, or go to HOLD if `stall`.
  - Otherwise go to WAIT.
- **WAIT**
  - `imem_req=0`.
  - On `imem_rvalid`:
    - `flush`: drop the word, go to ISSUE.
    - `stall`: capture the word into the skid buffer, go to HOLD.
    - Otherwise: deliver, go to ISSUE.
  - No `rvalid` and `flush`: go to DISCARD.
- **DISCARD**
  - Wait for `imem_rvalid`, drop the word, go to ISSUE.
  - Further flushes while in DISCARD leave the state unchanged.
- **HOLD**
  - The skid buffer is full.
  - `flush`: empty the buffer, go to ISSUE.
  - `~stall`: deliver the buffer, go to ISSUE.
- **Delivery condition:** `deliver = (WAIT & rvalid) | HOLD | (ISSUE & misaligned)`.
- **PC control:** `pc_hold = ~flush & ~(deliver & ~stall)`. `flush` always releases the PC.
- **IF/ID update priority:** flush > stall > deliver > bubble.
  - `flush`: `id_valid <= 0`.
  - `stall`: hold all IF/ID fields.
  - Deliver: `id_valid <= 1`, `id_instr`/`id_pc`/`id_pc4`/`id_fetch_err` loaded. `id_pc` is the `ia` at issue, which equals `ia` now because the PC was held.
  - Otherwise: `id_valid <= 0`, other fields keep their value.
- The skid buffer stores `rdata`; its pc equals `ia` because the PC is held.
- Never more than one outstanding request.

## Timing
- Reset values:
  - state ISSUE.
  - `id_valid`, `id_instr`, `id_pc`, `id_pc4`, `id_fetch_err` all 0.
  - `imem_req` 0 while `reset` is high.
  - `pc_hold` 1 while `reset` is high.
- Reset asserted mid-request: FSM returns to ISSUE immediately. A response that arrives afterwards is not tracked; memory is reset by the same signal.
- Throughput with latency-1 memory: one instruction every 2 cycles.
  - Edge N: issue.
  - Cycle N+1: `rvalid`, `pc_hold=0`.
  - Edge N+1: IF/ID loaded, PC advances.
- Latency L response: `id_valid` rises at edge N+L.
- `flush` and `rvalid` in the same cycle: the response is dropped.
- `flush` and `stall` in the same cycle: flush wins.
- `pc_hold` is combinational from state and inputs. It must be valid before the PC's clock edge.

## Structure
- Package `cpu_pkg` holds:
  - `fetch_state_t` enum.
  - `NOP_INSTR = 32'h0000_0000`.
  - `RESET_VECTOR = 32'h8000_0000`.
- Sub-module `if_id_reg` implements the IF/ID register with flush/stall/load/bubble priority.
- `fetch_stage` contains the FSM, skid buffer and `pc_hold`/`imem_req` logic.

## Test plan
- **Basic fetch.** Reset, then `ia=8000_0000`, latency-1 memory returning 0x2008_0005. Required: `imem_req` high in cycle 0; `id_valid=1`, `id_instr=2008_0005`, `id_pc=8000_0000`, `id_pc4=8000_0004` after edge 1; `pc_hold=0` in cycle 1 only.
- **Stall during response.** `stall=1` when `rvalid` arrives. Required: state HOLD, `pc_hold=1`, IF/ID unchanged. Deassert `stall`: IF/ID loads the buffered word, PC released in that cycle.
- **Flush during wait.** Flush in cycle 1 with latency-3 memory. Required: `pc_hold=0` in cycle 1, state DISCARD; the returned word never appears on `id_instr`; the next request uses the new `ia` (e.g. 8000_0004).
- **Misaligned fetch.** `ia=8000_0002`. Required: `imem_req=0`, next edge `id_valid=1`, `id_fetch_err=1`, `id_instr=0`.
- **Wrap-around.** `ia=FFFF_FFFC`. Required: `id_pc4=0000_0000`.
- **Reset mid-request.** Assert `reset` in WAIT. Required: all outputs zero immediately, `imem_req=0`; after release the FSM is in ISSUE and `imem_req=1`.
